cp0_timer_unit: RTL and testbench



---
 rtl/cp0_timer_unit_if.sv | 23 ++
 rtl/cp0_timer_unit.sv | 174 +++++++++++++++++
 tb/tb_cp0_timer_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_timer_unit_if.sv
// Register bus of the CP0 timer block: one write port plus a normal and a
// debugger read port, both combinational.
interface cp0_timer_unit_if;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] data_i;
  logic [4:0]  rd_addr;
  logic [31:0] data_o;
  logic [4:0]  debugger_rd_addr;
  logic [31:0] debugger_data_o;

  // No handshake: a write is accepted on every clock edge where we=1, and
  // reads return the addressed register in the same cycle.
  modport master (
    output we, wr_addr, data_i, rd_addr, debugger_rd_addr,
    input  data_o, debugger_data_o
  );

  modport slave (
    input  we, wr_addr, data_i, rd_addr, debugger_rd_addr,
    output data_o, debugger_data_o
  );
endinterface

// File: rtl/cp0_timer_unit.sv
// Multi-channel CP0 timer: shared prescaled Count plus NUM_TIMERS compare
// channels (one-shot or periodic auto-reload) with latched, maskable pending bits.
module cp0_timer_unit #(
  parameter int NUM_TIMERS  = 2,
  parameter int COUNT_WIDTH = 32,
  parameter int PRESCALE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_timer_unit_if.slave       bus,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  irq_o
);

  localparam int              PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX      = PW'(PRESCALE - 1);
  localparam logic [4:0]      ADDR_COUNT   = 5'd0;
  localparam logic [4:0]      ADDR_PENDING = 5'd1;
  localparam logic [4:0]      ADDR_CONTROL = 5'd2;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  cnt_t                  count_q, count_d;
  cnt_t                  count_inc;
  cnt_t                  wdata;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  ce_q, ce_d;
  logic [NUM_TIMERS-1:0] per_q, per_d;
  logic [NUM_TIMERS-1:0] ie_q, ie_d;
  logic [NUM_TIMERS-1:0] pending_q, pending_d;
  logic [NUM_TIMERS-1:0] armed_q, armed_d;
  cnt_t                  cmp_q  [NUM_TIMERS];
  cnt_t                  cmp_d  [NUM_TIMERS];
  cnt_t                  ival_q [NUM_TIMERS];
  cnt_t                  ival_d [NUM_TIMERS];

  logic                  tick;
  logic                  wr_count, wr_pending, wr_control;
  logic [NUM_TIMERS-1:0] wr_cmp, wr_ival;
  logic [NUM_TIMERS-1:0] hit;
  logic [31:0]           reg_view [32];

  // Write decode
  always_comb begin
    wdata      = bus.data_i[COUNT_WIDTH-1:0];
    wr_count   = bus.we && (bus.wr_addr == ADDR_COUNT);
    wr_pending = bus.we && (bus.wr_addr == ADDR_PENDING);
    wr_control = bus.we && (bus.wr_addr == ADDR_CONTROL);
    wr_cmp     = '0;
    wr_ival    = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      wr_cmp[i]  = bus.we && (bus.wr_addr == 5'(4 + 2 * i));
      wr_ival[i] = bus.we && (bus.wr_addr == 5'(5 + 2 * i));
    end
  end

  // Prescaler and Count
  always_comb begin
    tick      = ce_q && (pre_q == PRE_MAX);
    count_inc = count_q + 1'b1;

    pre_d = pre_q;
    if (ce_q) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end

    // A Count write wins over the tick; the prescaler keeps its phase.
    count_d = count_q;
    if (wr_count) begin
      count_d = wdata;
    end else if (tick) begin
      count_d = count_inc;
    end
  end

  // Control register
  always_comb begin
    ce_d  = ce_q;
    per_d = per_q;
    ie_d  = ie_q;
    if (wr_control) begin
      ce_d  = bus.data_i[0];
      per_d = bus.data_i[8 +: NUM_TIMERS];
      ie_d  = bus.data_i[16 +: NUM_TIMERS];
    end
  end

  // Compare channels. Priority inside one cycle, lowest first:
  // W1C on pending, then match/reload, then a Compare write.
  always_comb begin
    pending_d = pending_q;
    armed_d   = armed_q;
    hit       = '0;
    if (wr_pending) begin
      pending_d = pending_q & ~bus.data_i[NUM_TIMERS-1:0];
    end
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cmp_d[i]  = cmp_q[i];
      ival_d[i] = ival_q[i];
      hit[i]    = tick && !wr_count && armed_q[i] && (count_inc == cmp_q[i]);

      if (hit[i]) begin
        pending_d[i] = 1'b1;
        if (per_q[i] && (ival_q[i] != '0)) begin
          cmp_d[i] = cmp_q[i] + ival_q[i];
        end else begin
          armed_d[i] = 1'b0;
        end
      end

      if (wr_cmp[i]) begin
        cmp_d[i]     = wdata;
        armed_d[i]   = 1'b1;
        pending_d[i] = 1'b0;
      end

      // Reload above already used the old interval.
      if (wr_ival[i]) begin
        ival_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      pre_q     <= '0;
      ce_q      <= 1'b1;
      per_q     <= '0;
      ie_q      <= '1;
      pending_q <= '0;
      armed_q   <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cmp_q[i]  <= '0;
        ival_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      pre_q     <= pre_d;
      ce_q      <= ce_d;
      per_q     <= per_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cmp_q[i]  <= cmp_d[i];
        ival_q[i] <= ival_d[i];
      end
    end
  end

  // One register view shared by both read ports; unmapped slots stay zero.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      reg_view[r] = '0;
    end
    reg_view[0]                      = 32'(count_q);
    reg_view[1]                      = 32'(pending_q);
    reg_view[2][0]                   = ce_q;
    reg_view[2][8 +: NUM_TIMERS]     = per_q;
    reg_view[2][16 +: NUM_TIMERS]    = ie_q;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      reg_view[4 + 2 * i] = 32'(cmp_q[i]);
      reg_view[5 + 2 * i] = 32'(ival_q[i]);
    end
  end

  assign bus.data_o          = reg_view[bus.rd_addr];
  assign bus.debugger_data_o = reg_view[bus.debugger_rd_addr];

  assign timer_int = pending_q & ie_q;
  assign irq_o     = |timer_int;

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Bench for cp0_timer_unit: two instances (2ch/32b/prescale 1 and 8ch/8b/prescale 4)
// driven by directed steps and random writes, checked against a cycle reference model.
module tb_cp0_timer_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_timer_unit_if bus_a ();
  cp0_timer_unit_if bus_b ();
  logic [1:0] int_a;
  logic       irq_a;
  logic [7:0] int_b;
  logic       irq_b;

  cp0_timer_unit #(.NUM_TIMERS(2), .COUNT_WIDTH(32), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .timer_int(int_a), .irq_o(irq_a)
  );

  cp0_timer_unit #(.NUM_TIMERS(8), .COUNT_WIDTH(8), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .timer_int(int_b), .irq_o(irq_b)
  );

  // ---------------- scoreboard counters ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  int              m_num [2] = '{2, 8};
  int              m_w   [2] = '{32, 8};
  int              m_p   [2] = '{1, 4};
  longint unsigned m_count [2];
  int              m_pre   [2];
  logic            m_ce    [2];
  logic [7:0]      m_per   [2];
  logic [7:0]      m_ie    [2];
  logic [7:0]      m_pend  [2];
  logic [7:0]      m_armed [2];
  longint unsigned m_cmp  [2][8];
  longint unsigned m_ival [2][8];

  function automatic logic [7:0] chan_mask(input int k);
    return 8'((16'd1 << m_num[k]) - 16'd1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0;
      m_pre[k]   = 0;
      m_ce[k]    = 1'b1;
      m_per[k]   = 8'h00;
      m_ie[k]    = chan_mask(k);
      m_pend[k]  = 8'h00;
      m_armed[k] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        m_cmp[k][i]  = 0;
        m_ival[k][i] = 0;
      end
    end
  endtask

  // Advance instance k by one clock given the write applied this cycle.
  task automatic model_step(input int k, input logic we, input logic [4:0] a, input logic [31:0] d);
    longint unsigned mask = (64'd1 << m_w[k]) - 64'd1;
    longint unsigned dm   = 64'(d) & mask;
    longint unsigned next_count;
    logic [7:0]      old_per;
    logic [7:0]      hits;
    longint unsigned old_ival [8];
    logic            tick;
    logic            count_wr;

    tick       = m_ce[k] && (m_pre[k] == m_p[k] - 1);
    count_wr   = we && (a == 5'd0);
    next_count = (m_count[k] + 1) & mask;
    old_per    = m_per[k];
    hits       = 8'h00;
    for (int i = 0; i < m_num[k]; i++) begin
      old_ival[i] = m_ival[k][i];
      hits[i]     = tick && !count_wr && m_armed[k][i] && (next_count == m_cmp[k][i]);
    end

    if (m_ce[k]) m_pre[k] = (m_pre[k] + 1) % m_p[k];
    if (count_wr) m_count[k] = dm;
    else if (tick) m_count[k] = next_count;

    if (we && a == 5'd2) begin
      m_ce[k]  = d[0];
      m_per[k] = d[15:8] & chan_mask(k);
      m_ie[k]  = d[23:16] & chan_mask(k);
    end
    if (we && a == 5'd1) m_pend[k] = m_pend[k] & ~d[7:0];

    for (int i = 0; i < m_num[k]; i++) begin
      if (hits[i]) begin
        m_pend[k][i] = 1'b1;
        if (old_per[i] && old_ival[i] != 0) m_cmp[k][i] = (m_cmp[k][i] + old_ival[i]) & mask;
        else m_armed[k][i] = 1'b0;
      end
      if (we && a == 5'(4 + 2 * i)) begin
        m_cmp[k][i]   = dm;
        m_armed[k][i] = 1'b1;
        m_pend[k][i]  = 1'b0;
      end
      if (we && a == 5'(5 + 2 * i)) m_ival[k][i] = dm;
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [4:0] a);
    int ai = int'(a);
    if (ai == 0) return 32'(m_count[k]);
    if (ai == 1) return {24'h0, m_pend[k]};
    if (ai == 2) return {8'h00, m_ie[k], m_per[k], 7'h00, m_ce[k]};
    if (ai >= 4 && ai < 4 + 2 * m_num[k]) begin
      if (ai % 2 == 0) return 32'(m_cmp[k][(ai - 4) / 2]);
      return 32'(m_ival[k][(ai - 4) / 2]);
    end
    return 32'h0;
  endfunction

  function automatic logic [7:0] model_int(input int k);
    return m_pend[k] & m_ie[k];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
    if (k == 0) begin
      bus_a.we = 1'b1; bus_a.wr_addr = a; bus_a.data_i = d;
    end else begin
      bus_b.we = 1'b1; bus_b.wr_addr = a; bus_b.data_i = d;
    end
  endtask

  // One clock: update model, take the edge, then compare outputs and two random reads per DUT.
  task automatic step();
    if (rst) model_reset();
    else begin
      model_step(0, bus_a.we, bus_a.wr_addr, bus_a.data_i);
      model_step(1, bus_b.we, bus_b.wr_addr, bus_b.data_i);
    end
    @(posedge clk);
    #1;
    bus_a.we = 1'b0;
    bus_b.we = 1'b0;
    bus_a.rd_addr          = 5'($urandom_range(0, 31));
    bus_a.debugger_rd_addr = 5'($urandom_range(0, 31));
    bus_b.rd_addr          = 5'($urandom_range(0, 31));
    bus_b.debugger_rd_addr = 5'($urandom_range(0, 31));
    #1;
    chk("a_data_o",   bus_a.data_o,          model_read(0, bus_a.rd_addr));
    chk("a_dbg_o",    bus_a.debugger_data_o, model_read(0, bus_a.debugger_rd_addr));
    chk("a_int",      32'(int_a),            32'(model_int(0)));
    chk("a_irq",      32'(irq_a),            32'(|model_int(0)));
    chk("b_data_o",   bus_b.data_o,          model_read(1, bus_b.rd_addr));
    chk("b_dbg_o",    bus_b.debugger_data_o, model_read(1, bus_b.debugger_rd_addr));
    chk("b_int",      32'(int_b),            32'(model_int(1)));
    chk("b_irq",      32'(irq_b),            32'(|model_int(1)));
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    set_wr(k, a, d);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reg(input string tag, input int k, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    if (k == 0) begin
      bus_a.rd_addr = a; #1; v = bus_a.data_o;
    end else begin
      bus_b.rd_addr = a; #1; v = bus_b.data_o;
    end
    chk(tag, v, exp);
  endtask

  function automatic logic int_bit(input int k, input int i);
    return (k == 0) ? int_a[i] : int_b[i];
  endfunction

  task automatic wait_int(input string tag, input int k, input int i, input int bound);
    int n = 0;
    while (int_bit(k, i) !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(int_bit(k, i)), 32'd1);
  endtask

  task automatic idle_until(input string tag, input int k, input longint unsigned target);
    int n = 0;
    while (m_count[k] != target && n < 2000) begin
      step();
      n++;
    end
    chk_reg(tag, k, 5'd0, 32'(target));
  endtask

  task automatic rand_write(input int k);
    logic [4:0]  a = 5'($urandom_range(0, 21));
    logic [31:0] d = $urandom;
    if (a == 5'd2) d[0] = ($urandom_range(0, 3) != 0);
    if (k == 0) begin
      if (a == 5'd0 || a == 5'd4 || a == 5'd6) d = 32'(m_count[0]) + $urandom_range(2, 30);
      if (a == 5'd5 || a == 5'd7) d = $urandom_range(0, 6);
    end
    set_wr(k, a, d);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] frozen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    bus_a.we = 1'b0; bus_a.wr_addr = '0; bus_a.data_i = '0;
    bus_a.rd_addr = '0; bus_a.debugger_rd_addr = '0;
    bus_b.we = 1'b0; bus_b.wr_addr = '0; bus_b.data_i = '0;
    bus_b.rd_addr = '0; bus_b.debugger_rd_addr = '0;
    rst = 1'b1;
    model_reset();
    step();
    step();
    chk_reg("rst_ctrl_b", 1, 5'd2, 32'h00FF_0001);
    chk_reg("rst_ctrl_a", 0, 5'd2, 32'h0003_0001);
    chk_reg("rst_count_a", 0, 5'd0, 32'h0);
    rst = 1'b0;

    // One-shot on instance A
    wr(0, 5'd0, 32'h10);
    wr(0, 5'd4, 32'h20);
    wait_int("oneshot_rise", 0, 0, 40);
    chk_reg("oneshot_count", 0, 5'd0, 32'h20);
    idle(5);
    chk("oneshot_hold", 32'(int_a[0]), 32'd1);
    wr(0, 5'd1, 32'h1);
    chk("oneshot_w1c", 32'(int_a[0]), 32'd0);
    wr(0, 5'd0, 32'hFFFF_FFF8);
    idle(48);
    chk("oneshot_no_refire", 32'(int_a[0]), 32'd0);
    wr(0, 5'd0, 32'h10);
    wr(0, 5'd4, 32'h14);
    wait_int("oneshot2_rise", 0, 0, 20);
    chk_reg("oneshot2_count", 0, 5'd0, 32'h14);
    wr(0, 5'd4, 32'h1000);
    chk("cmp_write_clears", 32'(int_a[0]), 32'd0);

    // Periodic on instance A
    wr(0, 5'd2, 32'h0003_0101);
    wr(0, 5'd5, 32'h5);
    wr(0, 5'd0, 32'h0);
    wr(0, 5'd4, 32'h8);
    wait_int("per_hit1", 0, 0, 20);
    chk_reg("per_count1", 0, 5'd0, 32'h08);
    chk_reg("per_reload", 0, 5'd4, 32'h0D);
    wr(0, 5'd1, 32'h1);
    wait_int("per_hit2", 0, 0, 20);
    chk_reg("per_count2", 0, 5'd0, 32'h0D);
    wr(0, 5'd1, 32'h1);
    wait_int("per_hit3", 0, 0, 20);
    chk_reg("per_count3", 0, 5'd0, 32'h12);
    wr(0, 5'd1, 32'h1);
    wr(0, 5'd5, 32'h0);
    wait_int("ival0_hit", 0, 0, 20);
    chk_reg("ival0_count", 0, 5'd0, 32'h17);
    wr(0, 5'd1, 32'h1);
    idle(30);
    chk("ival0_single", 32'(int_a[0]), 32'd0);
    chk_reg("ival0_cmp", 0, 5'd4, 32'h17);

    // Collisions on instance A
    wr(0, 5'd2, 32'h0003_0001);
    wr(0, 5'd0, 32'h100);
    wr(0, 5'd4, 32'h105);
    idle_until("col_w1c_pre", 0, 64'h104);
    wr(0, 5'd1, 32'h1);
    chk_reg("col_w1c_pend", 0, 5'd1, 32'h1);
    wr(0, 5'd1, 32'h1);
    wr(0, 5'd0, 32'h200);
    wr(0, 5'd4, 32'h205);
    idle_until("col_cmp_pre", 0, 64'h204);
    wr(0, 5'd4, 32'h300);
    chk_reg("col_cmp_pend", 0, 5'd1, 32'h0);
    chk_reg("col_cmp_val", 0, 5'd4, 32'h300);
    wr(0, 5'd0, 32'h2FD);
    idle_until("col_cnt_pre", 0, 64'h2FF);
    wr(0, 5'd0, 32'h50);
    chk_reg("col_cnt_val", 0, 5'd0, 32'h50);
    chk_reg("col_cnt_pend", 0, 5'd1, 32'h0);

    // Interval write in the reload cycle uses the old interval
    wr(0, 5'd2, 32'h0003_0201);
    wr(0, 5'd7, 32'h4);
    wr(0, 5'd0, 32'h400);
    wr(0, 5'd6, 32'h404);
    idle_until("ival_col_pre", 0, 64'h403);
    wr(0, 5'd7, 32'h20);
    chk_reg("ival_col_cmp", 0, 5'd6, 32'h408);
    chk_reg("ival_col_ival", 0, 5'd7, 32'h20);

    // Masking
    wr(0, 5'd2, 32'h0001_0201);
    chk("mask_int1", 32'(int_a[1]), 32'd0);
    chk_reg("mask_pend", 0, 5'd1, 32'h2);
    chk("mask_irq", 32'(irq_a), 32'd0);
    wr(0, 5'd2, 32'h0003_0201);
    chk("unmask_irq", 32'(irq_a), 32'd1);

    // Prescaler and CE on instance B
    wr(1, 5'd0, 32'h0);
    idle(40);
    chk_reg("pre_40clk", 1, 5'd0, 32'd10);
    wr(1, 5'd2, 32'h00FF_0000);
    frozen = 32'(m_count[1]);
    idle(8);
    chk_reg("ce_frozen", 1, 5'd0, frozen);
    wr(1, 5'd2, 32'h00FF_0001);
    idle(40);
    chk_reg("ce_resume", 1, 5'd0, frozen + 32'd10);

    // Wrap-around on instance B
    wr(1, 5'd2, 32'h00FF_0201);
    wr(1, 5'd7, 32'h10);
    wr(1, 5'd0, 32'hFE);
    wr(1, 5'd6, 32'h02);
    wait_int("wrap_hit", 1, 1, 40);
    chk_reg("wrap_count", 1, 5'd0, 32'h02);
    chk_reg("wrap_cmp", 1, 5'd6, 32'h12);
    wr(1, 5'd1, 32'h2);
    wr(1, 5'd0, 32'hF0);
    wr(1, 5'd6, 32'hF8);
    wait_int("wrap2_hit", 1, 1, 60);
    chk_reg("wrap2_count", 1, 5'd0, 32'hF8);
    chk_reg("wrap2_cmp", 1, 5'd6, 32'h08);

    // Asynchronous reset mid-count
    chk("pre_rst_irq", 32'(irq_a), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_int_a", 32'(int_a), 32'd0);
    chk("rst_irq_a", 32'(irq_a), 32'd0);
    chk("rst_int_b", 32'(int_b), 32'd0);
    chk_reg("rst_ctrl_b2", 1, 5'd2, 32'h00FF_0001);
    chk_reg("rst_cmp1_b", 1, 5'd6, 32'h0);
    chk_reg("rst_count_b", 1, 5'd0, 32'h0);
    step();
    rst = 1'b0;

    // Random writes on both instances
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) == 0) rand_write(k);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
